// File: rtl/ps2_uart_tx_pkg.sv
// Shared constants and types for the PS2 UART transmit path.
// Parity support elsewhere is enabled by defining PS2_UART_TX_PARITY_EN.
package ps2_uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  // 3-bit state encoding, kept as plain constants for legacy tooling
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

endpackage

// File: rtl/ps2_uart_tx_if.sv
// Byte handshake and serial line bundle between the FT2232 side and the PS2 transmitter.
interface ps2_uart_tx_if;
  import ps2_uart_pkg::*;

  uart_byte_t TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic       TX;
  logic       TX_BUSY;

  modport master (output TX_DATA, output TX_VALID, input TX_READY, input TX, input TX_BUSY);
  modport slave  (input TX_DATA, input TX_VALID, output TX_READY, output TX, output TX_BUSY);
endinterface

// File: rtl/ps2_uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
module ps2_uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 521
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == LAST)) cnt_next = '0;
  end

  // Tick is registered from the next count so it is high exactly while cnt_q == LAST
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      bit_tick <= 1'b0;
    end else begin
      cnt_q    <= cnt_next;
      bit_tick <= (cnt_next == LAST);
    end
  end

endmodule

// File: rtl/ps2_uart_tx.sv
// 8N1/8N2 UART transmitter towards the PS2 RX line; define PS2_UART_TX_PARITY_EN
// to insert an even-parity bit between data bit 7 and the stop bit(s).
module ps2_uart_tx
  import ps2_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 521,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic         CLK,
  input  logic         RST,
  ps2_uart_tx_if.slave bus
);

  logic [2:0]  state_q, state_next;
  uart_byte_t  shift_q, shift_next;
  logic [2:0]  bit_cnt_q, bit_cnt_next;
  logic        tx_q, tx_next;
  logic        ready_q, ready_next;
  logic        busy_q, busy_next;
  logic        bit_tick;
  logic        baud_clr_c;
`ifdef PS2_UART_TX_PARITY_EN
  logic        par_q, par_next;
`endif

  ps2_uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (CLK),
    .rst      (RST),
    .clear    (baud_clr_c),
    .bit_tick (bit_tick)
  );

  // Next-state and next-output logic; TX follows the current state one cycle later
  always_comb begin
    state_next   = state_q;
    shift_next   = shift_q;
    bit_cnt_next = bit_cnt_q;
    tx_next      = 1'b1;
`ifdef PS2_UART_TX_PARITY_EN
    par_next     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.TX_VALID && ready_q) begin
          state_next   = ST_START;
          shift_next   = bus.TX_DATA;
          bit_cnt_next = '0;
`ifdef PS2_UART_TX_PARITY_EN
          par_next     = ^bus.TX_DATA;
`endif
        end
      end
      ST_START: begin
        tx_next = 1'b0;
        if (bit_tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        tx_next = shift_q[0];
        if (bit_tick) begin
          shift_next   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          bit_cnt_next = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef PS2_UART_TX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef PS2_UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_next = par_q;
        if (bit_tick) state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        // bit_cnt has wrapped to 0 after the data bits and now counts stop bits
        if (bit_tick) begin
          if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
            state_next   = ST_IDLE;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    baud_clr_c = (state_next != state_q) || (state_q == ST_IDLE);
    ready_next = (state_next == ST_IDLE);
    busy_next  = (state_next != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
`ifdef PS2_UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_next;
      shift_q   <= shift_next;
      bit_cnt_q <= bit_cnt_next;
      tx_q      <= tx_next;
      ready_q   <= ready_next;
      busy_q    <= busy_next;
`ifdef PS2_UART_TX_PARITY_EN
      par_q     <= par_next;
`endif
    end
  end

  assign bus.TX       = tx_q;
  assign bus.TX_READY = ready_q;
  assign bus.TX_BUSY  = busy_q;

endmodule

// File: tb/tb_ps2_uart_tx.sv
// Bench for ps2_uart_tx: one instance with 1 stop bit, one with 2; honours PS2_UART_TX_PARITY_EN.
module tb_ps2_uart_tx;
  import ps2_uart_pkg::*;

  localparam int C = 4;
`ifdef PS2_UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int F1 = (10 + PB) * C;
  localparam int F2 = (11 + PB) * C;

  typedef struct { logic [11:0] bits; int n; } frame_t;
  typedef struct { logic [7:0] data; logic par; int gap; } vec_t;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  int     vec_cnt = 0;
  int     err_cnt = 0;
  int     rst_ev = 0;
  frame_t sb0[$];
  frame_t sb1[$];

  always #5 clk = ~clk;
  always @(posedge rst) rst_ev++;

  ps2_uart_tx_if bus0();
  ps2_uart_tx_if bus1();

  ps2_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut0 (.CLK(clk), .RST(rst), .bus(bus0));
  ps2_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut1 (.CLK(clk), .RST(rst), .bus(bus1));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic tx_of(input int w);
    return (w == 0) ? bus0.TX : bus1.TX;
  endfunction
  function automatic logic rdy_of(input int w);
    return (w == 0) ? bus0.TX_READY : bus1.TX_READY;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 0) ? bus0.TX_BUSY : bus1.TX_BUSY;
  endfunction
  function automatic int sb_size(input int w);
    return (w == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic frame_t mk(input logic [7:0] d, input logic p, input int stops);
    frame_t f;
    int k;
    f.bits = '1;
    f.bits[0] = 1'b0;
    k = 1;
    for (int i = 0; i < 8; i++) begin f.bits[k] = d[i]; k++; end
    if (PB != 0) begin f.bits[k] = p; k++; end
    f.n = k + stops;
    return f;
  endfunction

  task automatic push(input int w, input frame_t f);
    if (w == 0) sb0.push_back(f); else sb1.push_back(f);
  endtask

  task automatic drive(input int w, input logic v, input logic [7:0] d);
    if (w == 0) begin bus0.TX_VALID = v; bus0.TX_DATA = d; end
    else        begin bus1.TX_VALID = v; bus1.TX_DATA = d; end
  endtask

  task automatic wait_ready(input int w);
    int t = 0;
    while (rdy_of(w) !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    check($sformatf("ready_wait_dut%0d", w), 32'(rdy_of(w)), 32'd1);
  endtask

  // Line monitor: samples each bit mid-period and compares against the scoreboard
  task automatic mon(input int w);
    frame_t f;
    int ev;
    int t;
    forever begin
      @(negedge clk);
      if (!rst && tx_of(w) === 1'b0) begin
        ev = rst_ev;
        check($sformatf("frame_expected_dut%0d", w), 32'(sb_size(w) > 0), 32'd1);
        if (sb_size(w) > 0) begin
          if (w == 0) f = sb0.pop_front(); else f = sb1.pop_front();
          for (int k = 0; k < f.n; k++) begin
            repeat ((k == 0) ? 2 : C) @(negedge clk);
            if (rst_ev != ev) break;
            check($sformatf("dut%0d_bit%0d", w, k), 32'(tx_of(w)), 32'(f.bits[k]));
          end
        end else begin
          t = 0;
          while (tx_of(w) !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  // Cycle-exact trace of one pulsed transfer: TX, TX_READY and TX_BUSY per cycle
  task automatic single_trace(input int w, input logic [7:0] d, input int F, input string nm);
    frame_t f;
    int rlow = 0;
    logic e;
    f = mk(d, ^d, (w == 0) ? 1 : 2);
    wait_ready(w);
    for (int i = 0; i < F + 3; i++) begin
      if (i == 0) begin drive(w, 1'b1, d); push(w, f); end
      else @(negedge clk);
      if (i == 1) drive(w, 1'b0, 8'h00);
      e = (i >= 2 && i < F + 2) ? f.bits[(i - 2) / C] : 1'b1;
      check($sformatf("%s_tx_c%0d", nm, i), 32'(tx_of(w)), 32'(e));
      check($sformatf("%s_busy_c%0d", nm, i), 32'(busy_of(w)), 32'(i >= 1 && i <= F));
      if (rdy_of(w) === 1'b0) rlow++;
    end
    check($sformatf("%s_ready_low_cycles", nm), 32'(rlow), 32'(F));
  endtask

  vec_t vecs[7];
  frame_t fa, fb;
  int run, maxrun, lowc;
  logic e;

  initial begin
    vecs[0] = '{8'h00, 1'b0, 0};
    vecs[1] = '{8'hFF, 1'b0, 0};
    vecs[2] = '{8'h01, 1'b1, 3};
    vecs[3] = '{8'h80, 1'b1, 0};
    vecs[4] = '{8'h5A, 1'b0, 1};
    vecs[5] = '{8'h07, 1'b1, 0};
    vecs[6] = '{8'hC3, 1'b0, 5};

    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
        check($sformatf("rst_tx_dut%0d", w), 32'(tx_of(w)), 32'd1);
        check($sformatf("rst_ready_dut%0d", w), 32'(rdy_of(w)), 32'd1);
        check($sformatf("rst_busy_dut%0d", w), 32'(busy_of(w)), 32'd0);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx", 32'(tx_of(0)), 32'd1);
    check("post_rst_ready", 32'(rdy_of(0)), 32'd1);
    check("post_rst_busy", 32'(busy_of(0)), 32'd0);

    single_trace(0, 8'hA5, F1, "a5");
    repeat (3) @(negedge clk);

    // Back-to-back 0x00 then 0xFF with TX_VALID held
    fa = mk(8'h00, 1'b0, 1);
    fb = mk(8'hFF, 1'b0, 1);
    wait_ready(0);
    run = 0; maxrun = 0;
    drive(0, 1'b1, 8'h00); push(0, fa);
    for (int i = 0; i < 2 * F1 + 4; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) begin drive(0, 1'b1, 8'hFF); push(0, fb); end
      if (i == F1 + 2) drive(0, 1'b0, 8'hFF);
      if (i >= 2 && i < F1 + 2) e = fa.bits[(i - 2) / C];
      else if (i >= F1 + 3 && i < 2 * F1 + 3) e = fb.bits[(i - F1 - 3) / C];
      else e = 1'b1;
      check($sformatf("b2b_tx_c%0d", i), 32'(tx_of(0)), 32'(e));
      if (tx_of(0) === 1'b0) begin run++; if (run > maxrun) maxrun = run; end
      else run = 0;
    end
    check("b2b_zero_low_run", 32'(maxrun), 32'((9 + PB) * C));
    repeat (3) @(negedge clk);

    // Table vectors through the scoreboard, with idle gaps or held valid
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].gap > 0) begin
        drive(0, 1'b0, 8'h00);
        repeat (vecs[v].gap) @(negedge clk);
      end
      drive(0, 1'b1, vecs[v].data);
      wait_ready(0);
      push(0, mk(vecs[v].data, vecs[v].par, 1));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_accepted", v), 32'(busy_of(0)), 32'd1);
    end
    drive(0, 1'b0, 8'h00);
    wait_ready(0);
    repeat (3) @(negedge clk);

    // Inputs ignored mid-frame; a held valid is taken only once back in IDLE
    wait_ready(0);
    drive(0, 1'b1, 8'h0F); push(0, mk(8'h0F, ^8'h0F, 1));
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      drive(0, logic'(i % 2), 8'h55);
    end
    drive(0, 1'b1, 8'h55); push(0, mk(8'h55, ^8'h55, 1));
    check("busy_mid_0f", 32'(busy_of(0)), 32'd1);
    wait_ready(0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    check("accept_55_after_idle", 32'(busy_of(0)), 32'd1);
    wait_ready(0);
    repeat (3) @(negedge clk);

    // Reset during data bit 3 of 0x3C
    wait_ready(0);
    drive(0, 1'b1, 8'h3C); push(0, mk(8'h3C, ^8'h3C, 1));
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    repeat (4 * C + 2) @(negedge clk);
    check("pre_rst_busy", 32'(busy_of(0)), 32'd1);
    check("pre_rst_bit3", 32'(tx_of(0)), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx_of(0)), 32'd1);
    check("async_rst_ready", 32'(rdy_of(0)), 32'd1);
    check("async_rst_busy", 32'(busy_of(0)), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lowc = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_of(0) !== 1'b1) lowc++;
    end
    check("after_rst_no_low", 32'(lowc), 32'd0);

    // Reset released while TX_VALID already high
    rst = 1'b1;
    drive(0, 1'b1, 8'h81); push(0, mk(8'h81, ^8'h81, 1));
    repeat (2) @(negedge clk);
    check("rst_valid_ready", 32'(rdy_of(0)), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rel_accept_ready", 32'(rdy_of(0)), 32'd0);
    check("rel_accept_busy", 32'(busy_of(0)), 32'd1);
    drive(0, 1'b0, 8'h00);
    wait_ready(0);
    repeat (3) @(negedge clk);

    single_trace(0, 8'h07, F1, "x07");
    single_trace(1, 8'h96, F2, "stop2");
    repeat (10) @(negedge clk);

    check("sb0_drained", 32'(sb0.size()), 32'd0);
    check("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish before time limit");
    $fatal(1);
  end

endmodule
